// File: rtl/sine_pwm_receiver.sv
// Serial frame receiver feeding a double-buffered PWM generator.
// Completed words load a pending duty that becomes active on PWM period boundaries.
module sine_pwm_receiver #(
    parameter int DATA_W = 32,
    parameter int PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SI,
    input  logic              SI_en,
    input  logic              soc,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              pwm_out,
    output logic              period_start
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   pending_duty;
    logic [DATA_W-1:0]   active_duty;
    logic [DATA_W-1:0]   pwm_cnt;
    logic [DATA_W-1:0]   word_next;
    logic                last_bit;
    logic                period_end;

    // Handshake: SI is taken only in SHIFT on cycles with SI_en=1; soc opens a frame.
    assign word_next  = {shift_reg[DATA_W-2:0], SI};
    assign last_bit   = (state == SHIFT) && SI_en && (bit_cnt == CNT_W'(DATA_W - 1));
    assign period_end = (pwm_cnt == DATA_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A soc on the last-bit edge starts the next frame without leaving SHIFT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (soc) state_next = SHIFT;
            SHIFT:   if (last_bit && !soc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            pending_duty <= '0;
            frame_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (last_bit) begin
                data_out     <= word_next;
                data_valid   <= 1'b1;
                pending_duty <= word_next;
            end
            if (state == IDLE) begin
                if (soc) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end
            end else if (soc) begin
                // Mid-frame soc drops the partial word and restarts counting.
                bit_cnt   <= '0;
                shift_reg <= '0;
                if (!last_bit) frame_err <= 1'b1;
            end else if (SI_en) begin
                shift_reg <= word_next;
                bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt     <= '0;
            active_duty <= '0;
            pwm_out     <= 1'b0;
        end else begin
            pwm_cnt <= period_end ? '0 : pwm_cnt + DATA_W'(1);
            // A word finishing on the boundary edge bypasses the pending register.
            if (period_end) active_duty <= last_bit ? word_next : pending_duty;
            pwm_out <= (pwm_cnt < active_duty);
        end
    end

    assign period_start = !rst && (pwm_cnt == '0);

endmodule

// File: tb/tb_sine_pwm_receiver.sv
// Directed bench for sine_pwm_receiver: frame reception, frame errors, PWM duty timing.
module tb_sine_pwm_receiver;

    localparam int DATA_W = 32;
    localparam int PERIOD = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              SI;
    logic              SI_en;
    logic              soc;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              frame_err;
    logic              pwm_out;
    logic              period_start;

    int n_cmp = 0;
    int n_err = 0;
    int dv_count = 0;

    sine_pwm_receiver #(.DATA_W(DATA_W), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .SI(SI), .SI_en(SI_en), .soc(soc),
        .data_out(data_out), .data_valid(data_valid), .busy(busy),
        .frame_err(frame_err), .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (data_valid === 1'b1) dv_count++;

    task automatic send_soc();
        soc = 1'b1; SI_en = 1'b1; SI = 1'b1;
        @(negedge clk);
        soc = 1'b0; SI_en = 1'b0; SI = 1'b0;
    endtask

    task automatic drive_bits(input logic [31:0] w, input int nbits, input bit gaps,
                              output int busy_drops);
        logic [31:0] word;
        word = w;
        busy_drops = 0;
        for (int i = 31; i > 31 - nbits; i--) begin
            if (gaps) begin
                repeat ($urandom_range(1, 5)) begin
                    if (busy !== 1'b1) busy_drops++;
                    SI_en = 1'b0; SI = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            if (busy !== 1'b1) busy_drops++;
            SI_en = 1'b1; SI = word[i];
            @(negedge clk);
        end
        SI_en = 1'b0; SI = 1'b0;
    endtask

    task automatic wait_period_start(output bit ok);
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        ok = (period_start === 1'b1);
    endtask

    // Counts pwm_out highs produced by the comparisons of one whole period.
    task automatic measure_period(output int highs, output bit ok);
        highs = 0;
        wait_period_start(ok);
        @(negedge clk);
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out === 1'b1) highs++;
            @(negedge clk);
        end
    endtask

    // Counts highs/samples from now through the next period_start cycle.
    task automatic remainder(output int highs, output int samples);
        int n;
        highs = 0; samples = 0; n = 0;
        while (period_start !== 1'b1 && n < 2 * PERIOD) begin
            if (pwm_out === 1'b1) highs++;
            samples++; n++;
            @(negedge clk);
        end
        if (pwm_out === 1'b1) highs++;
        samples++;
    endtask

    task automatic test_reset();
        rst = 1'b1; SI = 1'b0; SI_en = 1'b0; soc = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_out, data_valid, busy, frame_err, pwm_out, period_start} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout=%h dv=%b busy=%b ferr=%b pwm=%b ps=%b expected all 0",
                     data_out, data_valid, busy, frame_err, pwm_out, period_start);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int drops, highs, dv0;
        bit ok;
        dv0 = dv_count;
        send_soc();
        drive_bits(32'h0000_01F4, 32, 1'b0, drops);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 32'h0000_01F4) begin
            n_err++;
            $display("FAIL basic_data: got dv=%b dout=%h expected dv=1 dout=000001f4", data_valid, data_out);
        end
        n_cmp++;
        if (drops !== 0) begin
            n_err++;
            $display("FAIL basic_busy: got %0d busy-low cycles expected 0", drops);
        end
        @(negedge clk);
        n_cmp++;
        if (data_valid !== 1'b0 || dv_count - dv0 !== 1) begin
            n_err++;
            $display("FAIL basic_dv_pulse: got dv=%b pulses=%0d expected dv=0 pulses=1", data_valid, dv_count - dv0);
        end
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== 500) begin
            n_err++;
            $display("FAIL basic_pwm: got %0d highs (ok=%b) expected 500", highs, ok);
        end
    endtask

    task automatic test_gaps();
        int drops;
        send_soc();
        drive_bits(32'h0000_01F4, 32, 1'b1, drops);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 32'h0000_01F4) begin
            n_err++;
            $display("FAIL gaps_data: got dv=%b dout=%h expected dv=1 dout=000001f4", data_valid, data_out);
        end
        n_cmp++;
        if (drops !== 0) begin
            n_err++;
            $display("FAIL gaps_busy: got %0d busy-low cycles expected 0", drops);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL gaps_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_frame_error();
        int drops, dv0;
        dv0 = dv_count;
        send_soc();
        drive_bits(32'hFFFF_FFFF, 10, 1'b0, drops);
        send_soc();
        n_cmp++;
        if (frame_err !== 1'b1 || busy !== 1'b1 || data_out !== 32'h0000_01F4) begin
            n_err++;
            $display("FAIL ferr_set: got ferr=%b busy=%b dout=%h expected ferr=1 busy=1 dout=000001f4",
                     frame_err, busy, data_out);
        end
        drive_bits(32'hDEAD_BEEF, 32, 1'b0, drops);
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b1 || data_out !== 32'hDEAD_BEEF || dv_count - dv0 !== 1) begin
            n_err++;
            $display("FAIL ferr_frame: got ferr=%b dout=%h pulses=%0d expected ferr=1 dout=deadbeef pulses=1",
                     frame_err, data_out, dv_count - dv0);
        end
    endtask

    task automatic test_duty();
        int drops, highs, samples;
        bit ok;
        send_soc();
        drive_bits(32'h0000_0000, 32, 1'b0, drops);
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== 0) begin
            n_err++;
            $display("FAIL duty_zero: got %0d highs (ok=%b) expected 0", highs, ok);
        end
        send_soc();
        drive_bits(32'h0000_03E8, 32, 1'b0, drops);
        remainder(highs, samples);
        n_cmp++;
        if (highs !== 0) begin
            n_err++;
            $display("FAIL duty_hold_zero: got %0d highs in %0d cycles expected 0", highs, samples);
        end
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== PERIOD) begin
            n_err++;
            $display("FAIL duty_full: got %0d highs (ok=%b) expected 1000", highs, ok);
        end
        send_soc();
        drive_bits(32'h0000_0001, 32, 1'b0, drops);
        remainder(highs, samples);
        n_cmp++;
        if (highs !== samples) begin
            n_err++;
            $display("FAIL duty_hold_full: got %0d highs expected %0d", highs, samples);
        end
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== 1) begin
            n_err++;
            $display("FAIL duty_one: got %0d highs (ok=%b) expected 1", highs, ok);
        end
    endtask

    // Last bit lands on counter 999 (bypass) or 998 (pending path).
    task automatic test_boundary();
        int drops, highs;
        bit ok;
        wait_period_start(ok);
        repeat (967) @(negedge clk);
        send_soc();
        drive_bits(32'h0000_0064, 32, 1'b0, drops);
        n_cmp++;
        if (period_start !== 1'b1 || data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_align: got ps=%b dv=%b expected ps=1 dv=1", period_start, data_valid);
        end
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== 100) begin
            n_err++;
            $display("FAIL bypass_duty: got %0d highs (ok=%b) expected 100", highs, ok);
        end
        wait_period_start(ok);
        repeat (966) @(negedge clk);
        send_soc();
        drive_bits(32'h0000_00C8, 32, 1'b0, drops);
        measure_period(highs, ok);
        n_cmp++;
        if (!ok || highs !== 200) begin
            n_err++;
            $display("FAIL early_duty: got %0d highs (ok=%b) expected 200", highs, ok);
        end
    endtask

    task automatic test_mid_frame_reset();
        int drops;
        bit ok;
        wait_period_start(ok);
        send_soc();
        drive_bits(32'hFFFF_FFFF, 16, 1'b0, drops);
        n_cmp++;
        if (pwm_out !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL prereset: got pwm=%b busy=%b expected pwm=1 busy=1", pwm_out, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pwm_out !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || data_out !== '0) begin
            n_err++;
            $display("FAIL in_reset: got pwm=%b busy=%b ferr=%b dout=%h expected all 0",
                     pwm_out, busy, frame_err, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_soc();
        drive_bits(32'h1234_5678, 32, 1'b0, drops);
        n_cmp++;
        if (frame_err !== 1'b0 || data_out !== 32'h1234_5678 || data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: got ferr=%b dout=%h dv=%b expected ferr=0 dout=12345678 dv=1",
                     frame_err, data_out, data_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_frame_error();
        test_duty();
        test_boundary();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
